cyclic_decoder: RTL and testbench
=================================

# cyclic_decoder

Serial (7,4) cyclic-code decoder that sits directly downstream of the cyclic encoder. It consumes the encoder's bit stream, highest-degree bit first, and divides it by g(x) = 1 + x + x^3 in a syndrome LFSR. It corrects any single-bit error and hands the 4-bit message to the consumer over a valid/ready handshake, with a saturating count of corrected words.

## Interface

- CNT_W, 16, width of the corrected-word counter
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- in_bit  input  1  received code bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  decoder accepts a bit this cycle
- out_msg  output  4  corrected message {m3,m2,m1,m0}
- out_err  output  1  1 = nonzero syndrome, one bit was corrected
- out_syndrome  output  3  final syndrome {s2,s1,s0}
- out_valid  output  1  out_* fields valid
- out_ready  input  1  consumer accepts the word
- err_count  output  CNT_W  words with nonzero syndrome since reset, saturating

## Operation

- Codeword c(x) = c0 + c1x + … + c6x^6, systematic.
  - c0..c2 are parity; c3..c6 are m0..m3.
  - Bits arrive in the order c6, c5, …, c0.
- The FSM has three states: RECV, CORRECT, OUT.
- RECV
  - in_ready = 1.
  - On each accepted bit b (in_valid && in_ready), three updates happen:
    - Buffer shifts in b.
    - Syndrome register updates: fb = s2; s0' = b ^ fb; s1' = s0 ^ fb; s2' = s1.
    - Bit counter increments.
  - After the 7th accepted bit the FSM goes to CORRECT.
  - After 7 bits the buffer holds {c6..c0} and s = r(x) mod g(x).
- CORRECT (exactly one cycle, in_ready = 0)
  - Map the syndrome to an error position:
    - 001→c0, 010→c1, 100→c2, 011→c3, 110→c4, 111→c5, 101→c6.
    - 000 → no correction.
  - Flip that buffer bit and register out_msg = {c6,c5,c4,c3} of the corrected word.
  - Register out_syndrome = s and out_err = (s != 0).
  - If s != 0, err_count increments; it saturates at 2^CNT_W−1.
  - Go to OUT.
- OUT
  - out_valid = 1 and in_ready = 0.
  - out_* stay stable until out_ready.
  - On the handshake: clear the buffer, syndrome and bit counter, then go to RECV.
- Double errors are miscorrected to a wrong codeword. This is the inherent code limit and is not flagged.
- in_bit is ignored whenever in_valid && in_ready is 0.

## Timing

- Reset values:
  - State RECV.
  - in_ready = 1 from the first cycle after reset.
  - out_valid = 0, out_msg = 0, out_err = 0, out_syndrome = 0, err_count = 0.
  - Buffer, syndrome and bit counter = 0.
- The 7th bit is accepted at edge k.
  - CORRECT occupies cycle k→k+1.
  - out_valid is high from edge k+1.
- Handshake at edge j: out_valid = 0 and in_ready = 1 from edge j. The next frame can start in the same cycle.
- Minimum period is 9 cycles per word (7 RECV, 1 CORRECT, 1 OUT when out_ready is held high).
- Backpressure: if out_ready is low, OUT holds indefinitely with out_* unchanged.
- in_valid gaps mid-frame are legal. The bit counter does not advance, and nothing times out.
- rst mid-frame, or while in OUT, discards the partial or pending word. It restores all reset values at the next edge, including err_count.
- If rst and a handshake occur in the same cycle, rst wins.

## Structure

- Shared package cyclic_pkg holds:
  - N = 7, K = 4, G_POLY = 4'b1011 ({g3..g0}).
  - The state enum {RECV, CORRECT, OUT}.
  - A syndrome→error-position function, shared with the encoder's bench model.
- Sub-module cyclic_syndrome_lfsr holds the 3-bit divide-by-g register.
  - Ports: clk, rst, clr, shift, bit_in, syn[2:0].
  - The encoder team can reuse it.
- All other logic lives in cyclic_decoder: FSM, 7-bit buffer, 3-bit bit counter, correction mux, output registers and counter.

## Test plan

- Clean codewords, out_ready held high:
  - 7'b0001011 → out_msg = 4'b0001, out_err = 0, out_syndrome = 000.
  - 7'b1111111 → out_msg = 4'b1111, out_err = 0.
  - 7'b1000101 → out_msg = 4'b1000, out_err = 0.
- Single-error sweep: 7'b1000101 with each bit i = 0..6 flipped, 7 frames → each frame gives out_msg = 4'b1000 and out_err = 1.
  - Syndromes for i = 0..6 in order: 001, 010, 100, 011, 110, 111, 101.
  - err_count = 7 at the end.
- Backpressure and gaps:
  - Insert random in_valid gaps.
  - Hold out_ready = 0 for 20 cycles after out_valid rises.
  - Required: outputs stable, in_ready = 0 throughout, exactly one word delivered on release.
- Reset mid-frame: assert rst after 4 bits, then send 7'b0001011 → out_msg = 4'b0001, and no stale bits affect the syndrome.
- Counter saturation with CNT_W = 2: send 5 single-error frames → err_count reads 1, 2, 3, 3, 3.
- Back-to-back throughput: send 10 frames with in_valid and out_ready always high → one out_valid pulse every 9 cycles, and decoded messages match the encoder reference model.

Source files
------------

// File: rtl/cyclic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cyclic_pkg
// Description : Shared definitions for the (7,4) cyclic code blocks:
//               code dimensions, generator polynomial g(x) = 1 + x + x^3,
//               decoder state encoding and the syndrome -> error-position map.
// Revision    : 1.0 - initial release
// ============================================================================
package cyclic_pkg;

    localparam int         N      = 7;        // codeword length
    localparam int         K      = 4;        // message length
    localparam logic [3:0] G_POLY = 4'b1011;  // {g3,g2,g1,g0}

    typedef enum logic [1:0] {
        RECV    = 2'd0,
        CORRECT = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Syndrome of a single error at c_i is x^i mod g(x). Returns a one-hot
    // mask selecting the bit to flip (bit i = c_i), or zero for a clean word.
    function automatic logic [N-1:0] syn_to_err_mask(input logic [2:0] syn);
        logic [N-1:0] mask;
        case (syn)
            3'b001:  mask = 7'b0000001;
            3'b010:  mask = 7'b0000010;
            3'b100:  mask = 7'b0000100;
            3'b011:  mask = 7'b0001000;
            3'b110:  mask = 7'b0010000;
            3'b111:  mask = 7'b0100000;
            3'b101:  mask = 7'b1000000;
            default: mask = 7'b0000000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cyclic_syndrome_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : cyclic_syndrome_lfsr
// Description : 3-bit divide-by-g(x) register. Bits are fed highest degree
//               first; after a full word the register holds r(x) mod g(x).
// Ports       : clk, rst    - clock, synchronous active-high reset
//               clr         - synchronous clear (word boundary)
//               shift       - consume bit_in this cycle
//               bit_in      - next received bit
//               syn[2:0]    - current remainder {s2,s1,s0}
// Revision    : 1.0 - initial release
// ============================================================================
module cyclic_syndrome_lfsr
    import cyclic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift,
    input  logic       bit_in,
    output logic [2:0] syn
);

    logic [2:0] r_syn;
    logic       w_fb;

    // The top remainder bit overflows into x^3, which folds back as
    // x^3 = g0 + g1*x + g2*x^2 (mod g).
    assign w_fb = r_syn[2];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_syn <= 3'b000;
        end else if (shift) begin
            r_syn <= {r_syn[1] ^ (w_fb & G_POLY[2]),
                      r_syn[0] ^ (w_fb & G_POLY[1]),
                      bit_in   ^ (w_fb & G_POLY[0])};
        end
    end

    assign syn = r_syn;

endmodule
`default_nettype wire

// File: rtl/cyclic_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cyclic_decoder
// Description : Serial (7,4) cyclic-code decoder. Receives c6..c0 one bit at
//               a time, computes the syndrome, corrects a single-bit error
//               and presents the message over a valid/ready handshake.
//               Keeps a saturating count of corrected words.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_bit/in_valid   - received code bit stream
//               in_ready          - high while collecting bits
//               out_msg           - corrected message {m3,m2,m1,m0}
//               out_err           - nonzero syndrome (a bit was corrected)
//               out_syndrome      - final syndrome {s2,s1,s0}
//               out_valid/ready   - output handshake
//               err_count         - saturating corrected-word count
// Revision    : 1.0 - initial release
// ============================================================================
module cyclic_decoder
    import cyclic_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [K-1:0]     out_msg,
    output logic             out_err,
    output logic [2:0]       out_syndrome,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] c_LAST_BIT = 3'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_buf;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_syn;
    logic [N-1:0]     w_err_mask;
    logic [N-1:0]     w_fixed;
    logic             w_accept;
    logic             w_handshake;

    assign w_accept    = in_valid && in_ready;
    assign w_handshake = out_valid && out_ready;
    assign w_err_mask  = syn_to_err_mask(w_syn);
    assign w_fixed     = r_buf ^ w_err_mask;

    // ------------------------------------------------------------------
    // Syndrome divider
    // ------------------------------------------------------------------
    cyclic_syndrome_lfsr u_syndrome (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_handshake),
        .shift  (w_accept),
        .bit_in (in_bit),
        .syn    (w_syn)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            RECV: begin
                in_ready = 1'b1;
                if (in_valid && (r_bit_cnt == c_LAST_BIT)) begin
                    w_state_nxt = CORRECT;
                end
            end
            CORRECT: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = RECV;
                end
            end
            default: begin
                w_state_nxt = RECV;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive buffer and bit counter. Buffer bit i holds c_i once the
    // word is complete because c6 arrives first and shifts up.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf     <= '0;
            r_bit_cnt <= 3'd0;
        end else if (w_handshake) begin
            r_buf     <= '0;
            r_bit_cnt <= 3'd0;
        end else if (r_state == CORRECT) begin
            r_buf     <= w_fixed;
        end else if (w_accept) begin
            r_buf     <= {r_buf[N-2:0], in_bit};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers and error counter, loaded in the CORRECT cycle and
    // held until the next word is corrected.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_msg      <= '0;
            out_err      <= 1'b0;
            out_syndrome <= 3'b000;
            err_count    <= '0;
        end else if (r_state == CORRECT) begin
            out_msg      <= w_fixed[N-1:N-K];
            out_err      <= |w_syn;
            out_syndrome <= w_syn;
            if ((|w_syn) && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cyclic_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cyclic_decoder
// Description : Self-checking bench for cyclic_decoder. A polynomial-division
//               reference model produces codewords, syndromes and corrected
//               messages. A second instance with a 2-bit counter runs in
//               lockstep to observe saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cyclic_decoder;

    localparam logic [3:0] GEN = 4'b1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready;
    logic [3:0]  out_msg;
    logic        out_err;
    logic [2:0]  out_syndrome;
    logic        out_valid;
    logic [15:0] err_count;

    logic        s_in_ready;
    logic [3:0]  s_out_msg;
    logic        s_out_err;
    logic [2:0]  s_out_syndrome;
    logic        s_out_valid;
    logic [1:0]  s_err_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    cyclic_decoder #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .out_msg(out_msg), .out_err(out_err),
        .out_syndrome(out_syndrome), .out_valid(out_valid),
        .out_ready(out_ready), .err_count(err_count)
    );

    cyclic_decoder #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(s_in_ready), .out_msg(s_out_msg), .out_err(s_out_err),
        .out_syndrome(s_out_syndrome), .out_valid(s_out_valid),
        .out_ready(out_ready), .err_count(s_err_count)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] pmod(input logic [6:0] r);
        logic [6:0] t;
        t = r;
        for (int d = 6; d >= 3; d--) begin
            if (t[d]) t = t ^ ({3'b000, GEN} << (d - 3));
        end
        return t[2:0];
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] m);
        logic [6:0] cw;
        cw = {m, 3'b000};
        cw[2:0] = pmod(cw);
        return cw;
    endfunction

    function automatic logic [3:0] decode_msg(input logic [6:0] r);
        logic [6:0] f;
        logic [2:0] s;
        logic [6:0] one;
        f = r;
        s = pmod(r);
        if (s != 3'b000) begin
            for (int i = 0; i < 7; i++) begin
                one = 7'd1 << i;
                if (pmod(one) == s) f[i] = ~f[i];
            end
        end
        return f[6:3];
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},  in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_msg"},   out_msg, 0);
        chk({tag, "_out_err"},   out_err, 0);
        chk({tag, "_out_syn"},   out_syndrome, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_sat_count"}, s_err_count, 0);
    endtask

    // Called at a negedge with the decoder in RECV; returns at the negedge
    // following the edge that accepted the last bit.
    task automatic send_bits(input logic [6:0] cw, input int nbits, input bit gaps);
        for (int i = 6; i > 6 - nbits; i--) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                    @(negedge clk);
                end
            end
            chk("recv_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_bit   = cw[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [6:0] cw, input bit gaps);
        logic [2:0] s;
        s = pmod(cw);
        send_bits(cw, 7, gaps);
        if (s != 3'b000) exp_cnt++;
        chk("correct_in_ready",  in_ready, 0);
        chk("correct_out_valid", out_valid, 0);
        @(negedge clk);
        chk("out_valid",     out_valid, 1);
        chk("out_in_ready",  in_ready, 0);
        chk("out_msg",       out_msg, decode_msg(cw));
        chk("out_err",       out_err, (s != 3'b000));
        chk("out_syndrome",  out_syndrome, s);
        chk("err_count",     err_count, exp_cnt);
        chk("sat_err_count", s_err_count, sat3(exp_cnt));
        if (out_ready) begin
            @(negedge clk);
            chk("post_hs_valid", out_valid, 0);
            chk("post_hs_ready", in_ready, 1);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] syn_tab [7];
    logic [6:0] frames  [10];
    logic [3:0] msgs    [10];
    logic [6:0] cw;
    logic [3:0] m;
    int         sat_tab [5];
    int         f, b, got, last, quiet;

    initial begin
        syn_tab = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101};
        sat_tab = '{1, 2, 3, 3, 3};

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Clean codewords
        run_frame(7'b0001011, 1'b0);
        chk("clean0_msg", out_msg, 4'b0001);
        chk("clean0_err", out_err, 0);
        chk("clean0_syn", out_syndrome, 3'b000);
        run_frame(7'b1111111, 1'b0);
        chk("clean1_msg", out_msg, 4'b1111);
        chk("clean1_err", out_err, 0);
        run_frame(7'b1000101, 1'b0);
        chk("clean2_msg", out_msg, 4'b1000);
        chk("clean2_err", out_err, 0);

        // Single-error sweep
        for (int i = 0; i < 7; i++) begin
            cw = 7'b1000101 ^ (7'd1 << i);
            run_frame(cw, 1'b0);
            chk("sweep_msg", out_msg, 4'b1000);
            chk("sweep_err", out_err, 1);
            chk("sweep_syn", out_syndrome, syn_tab[i]);
        end
        chk("sweep_count", err_count, 7);
        chk("sweep_sat_count", s_err_count, 3);

        // Backpressure with input gaps and ignored bits while busy
        out_ready = 1'b0;
        m  = 4'($urandom);
        cw = encode(m) ^ (7'd1 << $urandom_range(0, 6));
        run_frame(cw, 1'b1);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            in_bit   = 1'($urandom);
            @(negedge clk);
            chk("bp_valid",    out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_msg",      out_msg, m);
            chk("bp_syn",      out_syndrome, pmod(cw));
            chk("bp_err",      out_err, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        quiet = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) quiet++;
            @(negedge clk);
        end
        chk("bp_single_word", quiet, 0);
        run_frame(encode(4'b0110), 1'b1);
        chk("bp_next_msg", out_msg, 4'b0110);

        // Reset mid-frame
        send_bits(7'b1111111, 4, 1'b0);
        do_reset();
        check_reset_state("midreset");
        run_frame(7'b0001011, 1'b0);
        chk("midreset_msg", out_msg, 4'b0001);
        chk("midreset_syn", out_syndrome, 3'b000);

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            m  = 4'($urandom);
            cw = encode(m) ^ (7'd1 << $urandom_range(0, 6));
            run_frame(cw, 1'b1);
            chk("sat_seq", s_err_count, sat_tab[k]);
            chk("sat_msg", out_msg, m);
        end

        // Back-to-back throughput
        do_reset();
        for (int k = 0; k < 10; k++) begin
            msgs[k]   = 4'($urandom);
            frames[k] = encode(msgs[k]);
            if ($urandom_range(0, 1) == 1) begin
                frames[k] = frames[k] ^ (7'd1 << $urandom_range(0, 6));
                exp_cnt++;
            end
        end
        f = 0; b = 6; got = 0; last = -1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            if (out_valid) begin
                chk("tput_msg", out_msg, msgs[got]);
                if (got > 0) chk("tput_period", cyc - last, 9);
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (f < 10) begin
                    in_valid = 1'b1;
                    in_bit   = frames[f][b];
                    if (b == 0) begin
                        b = 6;
                        f++;
                    end else begin
                        b--;
                    end
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("tput_words", got, 10);
        chk("tput_count", err_count, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
